credit_link_tx: RTL and testbench

- Reader/transmitter end of the router input buffer interface.
- Drains a show-ahead buffer (data valid at out while !empty; consume pops it) and drives flits onto an inter-router link.
- Flow control is credit-based against the downstream buffer's depth.
- Tracks packet framing (head/tail bits) and flags credit and framing protocol errors.

---
 rtl/router_pkg.sv | 14 +
 rtl/credit_counter.sv | 43 ++++
 rtl/credit_link_tx.sv | 106 ++++++++++
 tb/tb_credit_link_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and defaults for the router link datapath.
package router_pkg;
    localparam int BUFFER_WIDTH = 64;
    localparam int CREDIT_MAX   = 8;
    localparam int HEAD_BIT     = 63;
    localparam int TAIL_BIT     = 62;

    typedef logic [BUFFER_WIDTH-1:0] flit_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } tx_state_e;
endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter that saturates at credit_max and latches a sticky overflow flag.
module credit_counter #(
    parameter int credit_max = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               inc_i,
    input  logic                               dec_i,
    output logic [$clog2(credit_max+1)-1:0]    count_o,
    output logic                               ovf_o
);
    localparam int CW = $clog2(credit_max + 1);

    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unique case ({inc_i, dec_i})
            2'b10: begin
                if (count_q == CW'(credit_max)) ovf_d = 1'b1;
                else                            count_d = count_q + 1'b1;
            end
            // Caller only decrements with a non-zero count.
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= CW'(credit_max);
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign ovf_o   = ovf_q;
endmodule

// File: rtl/credit_link_tx.sv
// Credit-flow-controlled link transmitter draining a show-ahead buffer with packet framing checks.
// Optional CREDIT_LINK_TX_STATS_EN adds stall_cycles / flits_sent counters.
module credit_link_tx
    import router_pkg::*;
#(
    parameter int buffer_width = BUFFER_WIDTH,
    parameter int credit_max   = CREDIT_MAX,
    parameter int head_bit     = HEAD_BIT,
    parameter int tail_bit     = TAIL_BIT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [buffer_width-1:0]           buf_out,
    input  logic                              buf_empty,
    output logic                              buf_consume,
    output logic [buffer_width-1:0]           link_data,
    output logic                              link_valid,
    input  logic                              credit_in,
    output logic [$clog2(credit_max+1)-1:0]   credits,
    output logic                              pkt_active,
    output logic                              credit_err,
`ifdef CREDIT_LINK_TX_STATS_EN
    output logic [31:0]                       stall_cycles,
    output logic [31:0]                       flits_sent,
`endif
    output logic                              proto_err
);
    logic                    send;
    logic                    is_head, is_tail;
    logic [buffer_width-1:0] link_data_q;
    logic                    link_valid_q;
    logic                    proto_err_q, proto_viol;
    tx_state_e               state_q, state_d;

    assign send        = !buf_empty && (credits != '0) && !rst;
    assign buf_consume = send;
    assign is_head     = buf_out[head_bit];
    assign is_tail     = buf_out[tail_bit];

    credit_counter #(.credit_max(credit_max)) u_credits (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (credit_in),
        .dec_i   (send),
        .count_o (credits),
        .ovf_o   (credit_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            link_data_q  <= '0;
            link_valid_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            link_valid_q <= send;
            if (send)       link_data_q <= buf_out;
            if (proto_viol) proto_err_q <= 1'b1;
        end
    end

    // Framing errors are flagged but the offending flit is still forwarded.
    always_comb begin
        state_d    = state_q;
        proto_viol = 1'b0;
        if (send) begin
            unique case (state_q)
                IDLE: begin
                    if (!is_head)     proto_viol = 1'b1;
                    else if (!is_tail) state_d   = ACTIVE;
                end
                ACTIVE: begin
                    proto_viol = is_head;
                    if (is_tail) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pkt_active = (state_q == ACTIVE);
    end

    assign link_data  = link_data_q;
    assign link_valid = link_valid_q;
    assign proto_err  = proto_err_q;

`ifdef CREDIT_LINK_TX_STATS_EN
    logic [31:0] stall_cycles_q, flits_sent_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flits_sent_q   <= '0;
        end else begin
            if (!buf_empty && credits == '0) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (send)                        flits_sent_q   <= flits_sent_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flits_sent   = flits_sent_q;
`endif
endmodule

// File: tb/tb_credit_link_tx.sv
// Directed self-checking bench for credit_link_tx with a queue-backed show-ahead buffer model.
module tb_credit_link_tx;
    import router_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    flit_t       buf_out = '0;
    logic        buf_empty = 1'b1;
    logic        buf_consume;
    flit_t       link_data;
    logic        link_valid;
    logic        credit_in = 1'b0;
    logic [3:0]  credits;
    logic        pkt_active;
    logic        credit_err;
    logic        proto_err;
`ifdef CREDIT_LINK_TX_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flits_sent;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    flit_t q[$];

    localparam flit_t H_F  = 64'h8000_0000_0000_0000;
    localparam flit_t T_F  = 64'h4000_0000_0000_0000;
    localparam flit_t HT_F = 64'hC000_0000_0000_0000;

    credit_link_tx dut (
        .clk          (clk),
        .rst          (rst),
        .buf_out      (buf_out),
        .buf_empty    (buf_empty),
        .buf_consume  (buf_consume),
        .link_data    (link_data),
        .link_valid   (link_valid),
        .credit_in    (credit_in),
        .credits      (credits),
        .pkt_active   (pkt_active),
        .credit_err   (credit_err),
`ifdef CREDIT_LINK_TX_STATS_EN
        .stall_cycles (stall_cycles),
        .flits_sent   (flits_sent),
`endif
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    task automatic refresh();
        buf_empty = (q.size() == 0);
        buf_out   = (q.size() != 0) ? q[0] : '0;
        #1;
    endtask

    // Advance one clock; pop the model buffer if the DUT consumed at that edge.
    task automatic tick();
        logic c;
        c = buf_consume;
        @(posedge clk);
        #1;
        if (c && q.size() != 0) void'(q.pop_front());
        refresh();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        credit_in = 1'b0;
        q.delete();
        refresh();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (credits !== 4'd8) begin n_fail++; $display("FAIL reset_credits got %0d exp 8", credits); end
        n_checks++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL reset_link_valid got %b exp 0", link_valid); end
        n_checks++; if (link_data !== '0) begin n_fail++; $display("FAIL reset_link_data got %h exp 0", link_data); end
        n_checks++; if (pkt_active !== 1'b0 || credit_err !== 1'b0 || proto_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got act=%b cerr=%b perr=%b exp 000", pkt_active, credit_err, proto_err); end
        n_checks++; if (buf_consume !== 1'b0) begin n_fail++; $display("FAIL reset_consume got %b exp 0", buf_consume); end
    endtask

    task automatic test_basic_packet();
        flit_t exp_f[3];
        exp_f[0] = H_F | 64'h11;
        exp_f[1] = 64'h22;
        exp_f[2] = T_F | 64'h33;
        do_reset();
        for (int i = 0; i < 3; i++) q.push_back(exp_f[i]);
        refresh();
        n_checks++; if (buf_consume !== 1'b1) begin n_fail++; $display("FAIL basic_consume got %b exp 1", buf_consume); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (link_valid !== 1'b1 || link_data !== exp_f[i]) begin
                n_fail++; $display("FAIL basic_flit%0d got v=%b d=%h exp v=1 d=%h", i, link_valid, link_data, exp_f[i]); end
            n_checks++; if (credits !== 4'(7 - i)) begin n_fail++; $display("FAIL basic_credits%0d got %0d exp %0d", i, credits, 7 - i); end
            n_checks++; if (pkt_active !== (i < 2)) begin n_fail++; $display("FAIL basic_active%0d got %b exp %b", i, pkt_active, i < 2); end
        end
        tick();
        n_checks++; if (link_valid !== 1'b0 || link_data !== exp_f[2]) begin
            n_fail++; $display("FAIL basic_idle got v=%b d=%h exp v=0 d=%h", link_valid, link_data, exp_f[2]); end
        n_checks++; if (credit_err !== 1'b0 || proto_err !== 1'b0) begin
            n_fail++; $display("FAIL basic_errs got cerr=%b perr=%b exp 00", credit_err, proto_err); end
    endtask

    task automatic test_credit_exhaust();
        do_reset();
        for (int i = 0; i < 10; i++) q.push_back(HT_F | 64'(i));
        refresh();
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if (link_valid !== 1'b1 || link_data !== (HT_F | 64'(i))) begin
                n_fail++; $display("FAIL exhaust_flit%0d got v=%b d=%h exp v=1 d=%h", i, link_valid, link_data, HT_F | 64'(i)); end
        end
        n_checks++; if (credits !== 4'd0 || buf_consume !== 1'b0) begin
            n_fail++; $display("FAIL exhaust_stop got cr=%0d cons=%b exp cr=0 cons=0", credits, buf_consume); end
        tick();
        n_checks++; if (link_valid !== 1'b0) begin n_fail++; $display("FAIL exhaust_novalid got %b exp 0", link_valid); end
        credit_in = 1'b1;
        #1;
        n_checks++; if (buf_consume !== 1'b0) begin n_fail++; $display("FAIL exhaust_zero_credit_consume got %b exp 0", buf_consume); end
        tick();
        credit_in = 1'b0;
        #1;
        n_checks++; if (credits !== 4'd1 || buf_consume !== 1'b1 || link_valid !== 1'b0) begin
            n_fail++; $display("FAIL exhaust_return got cr=%0d cons=%b v=%b exp cr=1 cons=1 v=0", credits, buf_consume, link_valid); end
        tick();
        n_checks++; if (link_valid !== 1'b1 || link_data !== (HT_F | 64'd8) || credits !== 4'd0) begin
            n_fail++; $display("FAIL exhaust_resend got v=%b d=%h cr=%0d exp v=1 d=%h cr=0", link_valid, link_data, credits, HT_F | 64'd8); end
    endtask

    task automatic test_send_and_credit();
        do_reset();
        for (int i = 0; i < 5; i++) q.push_back(HT_F | 64'(i));
        refresh();
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (credits !== 4'd3) begin n_fail++; $display("FAIL simul_setup got %0d exp 3", credits); end
        q.push_back(HT_F | 64'h55);
        refresh();
        credit_in = 1'b1;
        #1;
        tick();
        credit_in = 1'b0;
        #1;
        n_checks++; if (credits !== 4'd3 || link_valid !== 1'b1 || link_data !== (HT_F | 64'h55)) begin
            n_fail++; $display("FAIL simul_hold got cr=%0d v=%b d=%h exp cr=3 v=1 d=%h", credits, link_valid, link_data, HT_F | 64'h55); end
    endtask

    task automatic test_credit_overflow();
        do_reset();
        credit_in = 1'b1;
        #1;
        tick();
        credit_in = 1'b0;
        #1;
        n_checks++; if (credits !== 4'd8 || credit_err !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set got cr=%0d err=%b exp cr=8 err=1", credits, credit_err); end
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", credit_err); end
        do_reset();
        n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", credit_err); end
    endtask

    task automatic test_proto_err();
        flit_t exp_f[3];
        exp_f[0] = H_F | 64'hA1;
        exp_f[1] = 64'hA2;
        exp_f[2] = H_F | 64'hA3;
        do_reset();
        for (int i = 0; i < 3; i++) q.push_back(exp_f[i]);
        refresh();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (link_valid !== 1'b1 || link_data !== exp_f[i]) begin
                n_fail++; $display("FAIL proto_flit%0d got v=%b d=%h exp v=1 d=%h", i, link_valid, link_data, exp_f[i]); end
            n_checks++; if (proto_err !== (i == 2)) begin n_fail++; $display("FAIL proto_err%0d got %b exp %b", i, proto_err, i == 2); end
        end
        n_checks++; if (pkt_active !== 1'b1) begin n_fail++; $display("FAIL proto_active got %b exp 1", pkt_active); end
        do_reset();
        q.push_back(64'hB0);
        refresh();
        tick();
        n_checks++; if (proto_err !== 1'b1 || pkt_active !== 1'b0 || link_data !== 64'hB0) begin
            n_fail++; $display("FAIL proto_idle_body got perr=%b act=%b d=%h exp perr=1 act=0 d=b0", proto_err, pkt_active, link_data); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        q.push_back(H_F | 64'h1);
        for (int i = 0; i < 6; i++) q.push_back(64'(i + 2));
        refresh();
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (credits !== 4'd2 || pkt_active !== 1'b1) begin
            n_fail++; $display("FAIL midrst_setup got cr=%0d act=%b exp cr=2 act=1", credits, pkt_active); end
        rst = 1'b1;
        #1;
        n_checks++; if (buf_consume !== 1'b0) begin n_fail++; $display("FAIL midrst_consume got %b exp 0", buf_consume); end
        tick();
        n_checks++; if (credits !== 4'd8 || pkt_active !== 1'b0 || link_valid !== 1'b0 || link_data !== '0) begin
            n_fail++; $display("FAIL midrst_state got cr=%0d act=%b v=%b d=%h exp cr=8 act=0 v=0 d=0", credits, pkt_active, link_valid, link_data); end
        rst = 1'b0;
        q.delete();
        refresh();
    endtask

`ifdef CREDIT_LINK_TX_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 10; i++) q.push_back(HT_F | 64'(i));
        refresh();
        for (int i = 0; i < 11; i++) tick();
        n_checks++; if (stall_cycles !== 32'd3 || flits_sent !== 32'd8) begin
            n_fail++; $display("FAIL stats got stall=%0d sent=%0d exp stall=3 sent=8", stall_cycles, flits_sent); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_packet();
        test_credit_exhaust();
        test_send_and_credit();
        test_credit_overflow();
        test_proto_err();
        test_reset_mid_packet();
`ifdef CREDIT_LINK_TX_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
